// File: rtl/apb_dmi_regbank.sv
`default_nettype none
// ============================================================================
//  Module      : apb_dmi_regbank
//  Description : APB4 slave register bank. G_NUM_REGS RW control registers
//                exported to hardware, a W1C status register set by
//                hardware events, an interrupt-enable register and a
//                registered interrupt output. Supports wait states, byte
//                strobes, secure-only registers and PSLVERR reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_dmi_regbank #(
    parameter int                    G_REGWIDTH    = 32,
    parameter int                    G_ADDR_WIDTH  = 6,
    parameter int                    G_NUM_REGS    = 8,
    parameter int                    G_WAIT_STATES = 0,
    parameter logic [G_NUM_REGS-1:0] G_SECURE_MASK = '0,
    parameter logic [G_REGWIDTH-1:0] G_RESET_VAL   = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             s_apb_psel,
    input  logic                             s_apb_penable,
    input  logic                             s_apb_pwrite,
    input  logic [2:0]                       s_apb_pprot,
    input  logic [G_ADDR_WIDTH-1:0]          s_apb_paddr,
    input  logic [G_REGWIDTH-1:0]            s_apb_pwdata,
    input  logic [G_REGWIDTH/8-1:0]          s_apb_pstrb,
    output logic                             s_apb_pready,
    output logic [G_REGWIDTH-1:0]            s_apb_prdata,
    output logic                             s_apb_pslverr,
    output logic [G_NUM_REGS*G_REGWIDTH-1:0] hw_ctrl,
    input  logic [G_REGWIDTH-1:0]            hw_event,
    output logic                             irq
);

    localparam int c_IDX_W  = G_ADDR_WIDTH - 2;
    localparam int c_NBYTES = G_REGWIDTH / 8;
    localparam logic [c_IDX_W-1:0] c_STATUS_IDX = c_IDX_W'(G_NUM_REGS);
    localparam logic [c_IDX_W-1:0] c_IRQEN_IDX  = c_IDX_W'(G_NUM_REGS + 1);

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_ACCESS = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_next;
    logic [3:0]            r_wait_cnt;
    logic [3:0]            w_wait_cnt_next;
    logic [c_IDX_W-1:0]    r_idx;
    logic                  r_write;
    logic                  r_err;
    logic [c_NBYTES-1:0]   r_strb;
    logic [G_REGWIDTH-1:0] r_ctrl [G_NUM_REGS];
    logic [G_REGWIDTH-1:0] r_status;
    logic [G_REGWIDTH-1:0] r_irq_en;
    logic                  r_irq;

    logic                  w_setup;
    logic                  w_pready;
    logic                  w_commit;
    logic                  w_secure_hit;
    logic                  w_setup_err;
    logic [c_IDX_W-1:0]    w_setup_idx;
    logic [G_REGWIDTH-1:0] w_bmask;
    logic [G_REGWIDTH-1:0] w_w1c;
    logic [G_REGWIDTH-1:0] w_rdata;
    logic                  w_unused_prot;

    // Only the non-secure bit of PPROT takes part in the decode.
    assign w_unused_prot = ^{s_apb_pprot[2], s_apb_pprot[0]};

    function automatic logic [G_REGWIDTH-1:0] f_merge(
        input logic [G_REGWIDTH-1:0] old_v,
        input logic [G_REGWIDTH-1:0] new_v,
        input logic [G_REGWIDTH-1:0] mask
    );
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    assign w_setup     = s_apb_psel && !s_apb_penable;
    assign w_setup_idx = s_apb_paddr[G_ADDR_WIDTH-1:2];
    assign w_pready    = (r_state == c_ST_ACCESS) && (r_wait_cnt == 4'd0) &&
                         s_apb_psel && s_apb_penable;
    assign w_commit    = w_pready && !r_err && r_write;

    // Secure-only check for the control register addressed in SETUP.
    always_comb begin
        w_secure_hit = 1'b0;
        for (int i = 0; i < G_NUM_REGS; i++) begin
            if ((int'(w_setup_idx) == i) && G_SECURE_MASK[i] && s_apb_pprot[1]) begin
                w_secure_hit = 1'b1;
            end
        end
    end

    assign w_setup_err = (s_apb_paddr[1:0] != 2'b00) || (w_setup_idx > c_IRQEN_IDX) ||
                         w_secure_hit;

    // Expand byte strobes captured in SETUP into a bit mask.
    generate
        for (genvar b = 0; b < c_NBYTES; b++) begin : g_bmask
            assign w_bmask[b*8 +: 8] = {8{r_strb[b]}};
        end
    endgenerate

    // Next-state and wait-counter logic; abort leaves ACCESS without pready.
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (w_setup) begin
                    w_state_next    = c_ST_ACCESS;
                    w_wait_cnt_next = 4'(G_WAIT_STATES);
                end
            end
            c_ST_ACCESS: begin
                if (!s_apb_psel || w_pready) begin
                    w_state_next = c_ST_IDLE;
                end else if (r_wait_cnt != 4'd0) begin
                    w_wait_cnt_next = r_wait_cnt - 4'd1;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // State register plus capture of the transfer attributes in SETUP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_ST_IDLE;
            r_wait_cnt <= 4'd0;
            r_idx      <= '0;
            r_write    <= 1'b0;
            r_err      <= 1'b0;
            r_strb     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            if ((r_state == c_ST_IDLE) && w_setup) begin
                r_idx   <= w_setup_idx;
                r_write <= s_apb_pwrite;
                r_err   <= w_setup_err;
                r_strb  <= s_apb_pstrb;
            end
        end
    end

    // Control registers take strobed write data on a clean commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < G_NUM_REGS; i++) begin
                r_ctrl[i] <= G_RESET_VAL;
            end
        end else if (w_commit) begin
            for (int i = 0; i < G_NUM_REGS; i++) begin
                if (int'(r_idx) == i) begin
                    r_ctrl[i] <= f_merge(r_ctrl[i], s_apb_pwdata, w_bmask);
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < G_NUM_REGS; g++) begin : g_hw_ctrl
            assign hw_ctrl[g*G_REGWIDTH +: G_REGWIDTH] = r_ctrl[g];
        end
    endgenerate

    assign w_w1c = (w_commit && (r_idx == c_STATUS_IDX)) ? (s_apb_pwdata & w_bmask) : '0;

    // STATUS clears on W1C and sets from hardware events (set wins);
    // IRQ_EN is a plain strobed RW register; irq is registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_status <= '0;
            r_irq_en <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_status <= (r_status & ~w_w1c) | hw_event;
            if (w_commit && (r_idx == c_IRQEN_IDX)) begin
                r_irq_en <= f_merge(r_irq_en, s_apb_pwdata, w_bmask);
            end
            r_irq <= |(r_status & r_irq_en);
        end
    end

    // Read mux over the current register contents.
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < G_NUM_REGS; i++) begin
            if (int'(r_idx) == i) begin
                w_rdata = r_ctrl[i];
            end
        end
        if (r_idx == c_STATUS_IDX) begin
            w_rdata = r_status;
        end
        if (r_idx == c_IRQEN_IDX) begin
            w_rdata = r_irq_en;
        end
    end

    assign s_apb_pready  = w_pready;
    assign s_apb_pslverr = w_pready && r_err;
    assign s_apb_prdata  = (w_pready && !r_err && !r_write) ? w_rdata : '0;
    assign irq           = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_apb_dmi_regbank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_dmi_regbank
//  Description : Self-checking bench for apb_dmi_regbank. Two instances
//                (3 wait states and zero wait states) share one APB bus,
//                selected per transfer, and are compared against a
//                register-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_dmi_regbank;

    localparam int          c_NREG     = 8;
    localparam logic [7:0]  c_SEC_MASK = 8'h02;
    localparam logic [31:0] c_RST_VAL  = 32'hA5A5A5A5;

    logic         clk = 1'b0;
    logic         rst;
    int           sel;
    logic         psel, penable, pwrite;
    logic [2:0]   pprot;
    logic [5:0]   paddr;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic [31:0]  hw_event;

    logic         pready_a, pslverr_a, irq_a;
    logic [31:0]  prdata_a;
    logic [255:0] hw_ctrl_a;
    logic         pready_b, pslverr_b, irq_b;
    logic [31:0]  prdata_b;
    logic [255:0] hw_ctrl_b;

    logic         mx_pready, mx_pslverr;
    logic [31:0]  mx_prdata;

    // Reference model state, one copy per instance.
    logic [31:0]  m_ctrl [2][c_NREG];
    logic [31:0]  m_status [2];
    logic [31:0]  m_irqen [2];

    int           compared   = 0;
    int           mismatched = 0;

    always #5 clk = ~clk;

    apb_dmi_regbank #(
        .G_REGWIDTH(32), .G_ADDR_WIDTH(6), .G_NUM_REGS(c_NREG), .G_WAIT_STATES(3),
        .G_SECURE_MASK(c_SEC_MASK), .G_RESET_VAL(c_RST_VAL)
    ) u_dut_a (
        .clk(clk), .rst(rst),
        .s_apb_psel(psel && (sel == 0)), .s_apb_penable(penable), .s_apb_pwrite(pwrite),
        .s_apb_pprot(pprot), .s_apb_paddr(paddr), .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb),
        .s_apb_pready(pready_a), .s_apb_prdata(prdata_a), .s_apb_pslverr(pslverr_a),
        .hw_ctrl(hw_ctrl_a), .hw_event(hw_event), .irq(irq_a)
    );

    apb_dmi_regbank #(
        .G_REGWIDTH(32), .G_ADDR_WIDTH(6), .G_NUM_REGS(c_NREG), .G_WAIT_STATES(0),
        .G_SECURE_MASK(c_SEC_MASK), .G_RESET_VAL(c_RST_VAL)
    ) u_dut_b (
        .clk(clk), .rst(rst),
        .s_apb_psel(psel && (sel == 1)), .s_apb_penable(penable), .s_apb_pwrite(pwrite),
        .s_apb_pprot(pprot), .s_apb_paddr(paddr), .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb),
        .s_apb_pready(pready_b), .s_apb_prdata(prdata_b), .s_apb_pslverr(pslverr_b),
        .hw_ctrl(hw_ctrl_b), .hw_event(hw_event), .irq(irq_b)
    );

    assign mx_pready  = (sel == 1) ? pready_b  : pready_a;
    assign mx_pslverr = (sel == 1) ? pslverr_b : pslverr_a;
    assign mx_prdata  = (sel == 1) ? prdata_b  : prdata_a;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < c_NREG; i++) m_ctrl[d][i] = c_RST_VAL;
            m_status[d] = '0;
            m_irqen[d]  = '0;
        end
    endtask

    function automatic logic [31:0] smask(input logic [3:0] strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{strb[b]}};
        return m;
    endfunction

    function automatic bit exp_err(input logic [5:0] addr, input logic [2:0] prot);
        int idx;
        idx = int'(addr[5:2]);
        if (addr[1:0] != 2'b00) return 1'b1;
        if (idx > c_NREG + 1) return 1'b1;
        if ((idx < c_NREG) && c_SEC_MASK[idx] && prot[1]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_read(input int d, input int idx);
        if (idx < c_NREG) return m_ctrl[d][idx];
        if (idx == c_NREG) return m_status[d];
        return m_irqen[d];
    endfunction

    function automatic logic [255:0] pack(input int d);
        logic [255:0] p;
        for (int i = 0; i < c_NREG; i++) p[i*32 +: 32] = m_ctrl[d][i];
        return p;
    endfunction

    function automatic logic exp_irq(input int d);
        return |(m_status[d] & m_irqen[d]);
    endfunction

    // One APB transfer on instance d, checked against the model. With b2b
    // set the bus is left selected so the next call's SETUP follows pready.
    task automatic xfer(input int d, input bit wr, input logic [5:0] addr,
                        input logic [31:0] wd, input logic [3:0] strb,
                        input logic [2:0] prot, input bit b2b, output logic [31:0] rd);
        int          idx, waits;
        bit          e_err;
        logic [31:0] e_rd, m;
        idx = int'(addr[5:2]);
        @(posedge clk); #1;
        sel = d; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
        pwdata = wd; pstrb = strb; pprot = prot;
        for (int k = 0; k < 2; k++) m_status[k] = m_status[k] | hw_event;
        e_err = exp_err(addr, prot);
        e_rd  = (!wr && !e_err) ? exp_read(d, idx) : 32'h0;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            if (mx_pready) break;
            waits++;
            if (waits > 40) begin
                compared++; mismatched++;
                $error("FAIL timeout: observed no pready expected pready within 40 cycles");
                break;
            end
        end
        rd = mx_prdata;
        chk("waits", 256'(waits), (d == 0) ? 256'd3 : 256'd0);
        chk("pslverr", 256'(mx_pslverr), 256'(e_err));
        if (!wr) chk("prdata", 256'(rd), 256'(e_rd));
        if (wr && !e_err) begin
            m = smask(strb);
            if (idx < c_NREG)       m_ctrl[d][idx] = (m_ctrl[d][idx] & ~m) | (wd & m);
            else if (idx == c_NREG) m_status[d]    = m_status[d] & ~(wd & m);
            else                    m_irqen[d]     = (m_irqen[d] & ~m) | (wd & m);
        end
        for (int k = 0; k < 2; k++) m_status[k] = m_status[k] | hw_event;
        if (!b2b) begin
            @(posedge clk); #1;
            psel = 1'b0; penable = 1'b0;
            chk("hw_ctrl", (d == 0) ? hw_ctrl_a : hw_ctrl_b, pack(d));
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          d, idx;
        logic [5:0]  addr;

        rst = 1'b0; sel = 0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        pprot = '0; paddr = '0; pwdata = '0; pstrb = '0; hw_event = '0;
        m_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_pready_a", 256'(pready_a), 256'd0);
        chk("rst_pslverr_a", 256'(pslverr_a), 256'd0);
        chk("rst_prdata_a", 256'(prdata_a), 256'd0);
        chk("rst_irq_a", 256'(irq_a), 256'd0);
        chk("rst_hw_ctrl_a", hw_ctrl_a, {8{c_RST_VAL}});
        chk("rst_hw_ctrl_b", hw_ctrl_b, {8{c_RST_VAL}});

        // Reset asserted in the ACCESS cycle of a CTRL[2] write (zero-wait part)
        @(posedge clk); #1;
        sel = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 6'h08;
        pwdata = 32'h0; pstrb = 4'hF; pprot = 3'b000;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk);
        chk("pre_rst_pready", 256'(pready_b), 256'd1);
        #1 rst = 1'b0;
        #1 chk("mid_rst_pready", 256'(pready_b), 256'd0);
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        m_reset();
        xfer(1, 1'b0, 6'h08, 32'h0, 4'h0, 3'b000, 1'b0, rd);
        chk("rst_ctrl2", 256'(rd), 256'(c_RST_VAL));
        xfer(1, 1'b0, 6'h20, 32'h0, 4'h0, 3'b000, 1'b0, rd);
        chk("rst_irq_b", 256'(irq_b), 256'd0);

        // Strobed write with three wait states
        xfer(0, 1'b1, 6'h08, 32'hFFFFFFFF, 4'hF, 3'b000, 1'b0, rd);
        xfer(0, 1'b1, 6'h08, 32'h11223344, 4'b0101, 3'b000, 1'b0, rd);
        chk("strb_hw_ctrl2", 256'(hw_ctrl_a[95:64]), 256'(32'hFF22FF44));
        xfer(0, 1'b0, 6'h08, 32'h0, 4'h0, 3'b000, 1'b0, rd);
        chk("strb_read", 256'(rd), 256'(32'hFF22FF44));
        xfer(0, 1'b1, 6'h0C, 32'hDEADBEEF, 4'h0, 3'b000, 1'b0, rd);

        // Errors: misaligned, out of map, non-secure access to secure CTRL[1]
        xfer(0, 1'b0, 6'h05, 32'h0, 4'h0, 3'b000, 1'b0, rd);
        xfer(0, 1'b1, 6'h28, 32'h0000DEAD, 4'hF, 3'b000, 1'b0, rd);
        xfer(0, 1'b1, 6'h04, 32'hCAFEF00D, 4'hF, 3'b010, 1'b0, rd);
        xfer(0, 1'b0, 6'h04, 32'h0, 4'h0, 3'b010, 1'b0, rd);
        xfer(0, 1'b0, 6'h04, 32'h0, 4'h0, 3'b000, 1'b0, rd);
        chk("secure_unchanged", 256'(rd), 256'(c_RST_VAL));
        xfer(0, 1'b1, 6'h04, 32'hCAFEF00D, 4'hF, 3'b000, 1'b0, rd);
        xfer(0, 1'b0, 6'h04, 32'h0, 4'h0, 3'b000, 1'b0, rd);
        chk("secure_write", 256'(rd), 256'(32'hCAFEF00D));

        // STATUS set by hw_event and irq timing
        hw_event = 32'h10;
        @(posedge clk); #1 hw_event = 32'h0;
        for (int k = 0; k < 2; k++) m_status[k] = m_status[k] | 32'h10;
        xfer(0, 1'b0, 6'h20, 32'h0, 4'h0, 3'b000, 1'b0, rd);
        chk("status_set", 256'(rd), 256'(32'h10));
        xfer(0, 1'b1, 6'h24, 32'h10, 4'hF, 3'b000, 1'b0, rd);
        chk("irq_lag", 256'(irq_a), 256'd0);
        @(posedge clk); #1;
        chk("irq_set", 256'(irq_a), 256'd1);
        hw_event = 32'h10;
        xfer(0, 1'b1, 6'h20, 32'h10, 4'hF, 3'b000, 1'b0, rd);
        hw_event = 32'h0;
        xfer(0, 1'b0, 6'h20, 32'h0, 4'h0, 3'b000, 1'b0, rd);
        chk("set_wins", 256'(rd), 256'(32'h10));
        xfer(0, 1'b1, 6'h20, 32'h10, 4'hF, 3'b000, 1'b0, rd);
        chk("irq_hold", 256'(irq_a), 256'd1);
        @(posedge clk); #1;
        chk("irq_clear", 256'(irq_a), 256'd0);
        xfer(0, 1'b0, 6'h20, 32'h0, 4'h0, 3'b000, 1'b0, rd);
        chk("status_clear", 256'(rd), 256'd0);

        // Abort: psel dropped during a wait state of a CTRL[0] write
        @(posedge clk); #1;
        sel = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 6'h00;
        pwdata = 32'h12345678; pstrb = 4'hF; pprot = 3'b000;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk);
        chk("abort_wait", 256'(pready_a), 256'd0);
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("abort_pready", 256'(pready_a), 256'd0);
        repeat (5) @(posedge clk);
        xfer(0, 1'b0, 6'h00, 32'h0, 4'h0, 3'b000, 1'b0, rd);

        // Back-to-back zero-wait writes to CTRL[0..3] then readback
        for (int i = 0; i < 4; i++)
            xfer(1, 1'b1, 6'(i * 4), $urandom, 4'hF, 3'b000, (i < 3), rd);
        for (int i = 0; i < 4; i++)
            xfer(1, 1'b0, 6'(i * 4), 32'h0, 4'h0, 3'b000, (i < 3), rd);
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 80; n++) begin
            d    = int'($urandom_range(0, 1));
            idx  = int'($urandom_range(0, 11));
            addr = {4'(idx), 2'b00};
            if ($urandom_range(0, 9) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            xfer(d, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
                 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), rd);
        end
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("final_irq_a", 256'(irq_a), 256'(exp_irq(0)));
        chk("final_irq_b", 256'(irq_b), 256'(exp_irq(1)));
        chk("final_hw_ctrl_a", hw_ctrl_a, pack(0));
        chk("final_hw_ctrl_b", hw_ctrl_b, pack(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of run expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/apb_dmi_regbank.md
Name: apb_dmi_regbank

Overview:
Parametrised APB4 slave register bank, the next generation of the team's dmi register block. Adds configurable register count, programmable wait states, byte strobes, per-register secure-access protection, a hardware-set W1C status register with interrupt enables, and full PSLVERR reporting. It sits behind the SoC APB interconnect and exports its control registers to hardware.

Parameters:
G_REGWIDTH, 32, data width; must be a multiple of 8.
G_ADDR_WIDTH, 6, APB address width; 2^(G_ADDR_WIDTH-2) >= G_NUM_REGS+2.
G_NUM_REGS, 8, number of RW control registers (1..64).
G_WAIT_STATES, 0, extra ACCESS cycles before PREADY (0..15).
G_SECURE_MASK, 0, G_NUM_REGS-bit mask; bit i=1 makes CTRL[i] secure-only.
G_RESET_VAL, 0, reset value of every CTRL register.

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
s_apb_psel  input  1  APB select
s_apb_penable  input  1  APB enable
s_apb_pwrite  input  1  1=write
s_apb_pprot  input  3  protection; bit1=1 means non-secure
s_apb_paddr  input  G_ADDR_WIDTH  byte address
s_apb_pwdata  input  G_REGWIDTH  write data
s_apb_pstrb  input  G_REGWIDTH/8  byte-lane write strobes
s_apb_pready  output  1  transfer complete
s_apb_prdata  output  G_REGWIDTH  read data
s_apb_pslverr  output  1  transfer error
hw_ctrl  output  G_NUM_REGS*G_REGWIDTH  CTRL register contents; CTRL[i] occupies slice i
hw_event  input  G_REGWIDTH  per-bit level event, sets STATUS bits
irq  output  1  interrupt request

Behaviour:
- Clock is clk. Reset is rst, asynchronous and active-low. While rst=0: FSM=IDLE, pready=0, prdata=0, pslverr=0, CTRL[*]=G_RESET_VAL, STATUS=0, IRQ_EN=0, irq=0.
- Register map, word index idx=paddr[G_ADDR_WIDTH-1:2]:
  - idx 0..G_NUM_REGS-1: CTRL[idx], RW.
  - idx G_NUM_REGS: STATUS, W1C.
  - idx G_NUM_REGS+1: IRQ_EN, RW.
- FSM states: IDLE, ACCESS.
  - IDLE->ACCESS on psel=1 and penable=0 (SETUP phase). Address, direction, pprot and pstrb are captured and decoded. Wait counter is loaded with G_WAIT_STATES.
  - In ACCESS the counter decrements each cycle while nonzero.
  - pready is driven from registered state and is 1 exactly when FSM=ACCESS, counter=0, psel=1 and penable=1.
  - With G_WAIT_STATES=0 there are zero wait states. Otherwise pready rises G_WAIT_STATES cycles after the first ACCESS cycle.
  - ACCESS->IDLE on the cycle pready=1.
  - Abort: if psel drops in ACCESS before pready, go to IDLE, commit no write, keep pready=0.
- Error decode: pslverr=1 with pready on any of the following:
  - paddr[1:0]!=0;
  - idx>G_NUM_REGS+1;
  - non-secure access (pprot[1]=1) to CTRL[i] with G_SECURE_MASK[i]=1.
  - Errored writes change no state. Errored reads return prdata=0.
- pslverr and prdata are 0 whenever pready=0.
- Writes commit at the clk edge where pready=1 and pslverr=0. Only bytes with pstrb=1 are affected. pstrb=0 is a legal no-op write with pslverr=0.
- STATUS update each cycle: STATUS_next = (STATUS & ~w1c_bits) | hw_event.
  - w1c_bits = strobed pwdata bits of a committing STATUS write.
  - If set and clear hit the same bit in the same cycle, set wins.
- Reads return the current register value, sampled in the pready cycle.
- irq = |(STATUS & IRQ_EN), registered. It updates one cycle after a STATUS or IRQ_EN change.
- hw_ctrl reflects CTRL writes from the cycle after commit.
- Reset asserted mid-transfer: FSM returns to IDLE immediately, no partial commit, pready=0. The next SETUP after reset release is serviced normally.
- Back-to-back transfers: a SETUP in the cycle after pready is accepted. There are no dead cycles beyond APB protocol.

Test Plan:
- Reset/defaults (G_RESET_VAL=0xA5A5A5A5): pulse rst=0 mid-write to CTRL[2] -> pready=0 immediately. After release, read CTRL[2]=0xA5A5A5A5, STATUS=0, irq=0.
- Strobes, wait states (G_WAIT_STATES=3): write 0x11223344 to addr 0x08 with pstrb=0101 over prior 0xFFFFFFFF -> pready exactly 3 cycles after first ACCESS. Read back 0xFF22FF44. hw_ctrl slice 2 = 0xFF22FF44.
- Errors: read addr 0x05 -> pslverr=1, prdata=0. Write 0xDEAD to idx G_NUM_REGS+2 -> pslverr=1, no register changes. With G_SECURE_MASK bit1=1, non-secure write to CTRL[1] -> pslverr=1, value unchanged; secure write succeeds.
- STATUS/irq: hw_event bit4 pulses one cycle -> STATUS=0x10. Write IRQ_EN=0x10 -> irq=1 one cycle after commit. Write STATUS=0x10 with hw_event bit4 high that cycle -> STATUS stays 0x10. Repeat with hw_event low -> STATUS=0, irq=0 next cycle.
- Abort and back-to-back: drop psel during a wait state of a CTRL[0] write -> CTRL[0] unchanged. Then 4 back-to-back zero-wait writes to CTRL[0..3] -> each completes in 2 cycles, readback matches.
